// File: rtl/dual_port_block_memory_pkg.sv
// Shared encodings and default widths for the dual-port block memory.
// Both the instruction and data cache ports use these definitions.
package dual_port_block_memory_pkg;

  localparam int unsigned DefAddrW     = 28;
  localparam int unsigned DefDataW     = 128;
  localparam int unsigned DefDepthLog2 = 8;
  localparam int unsigned DefLatency   = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic {
    OwnerI = 1'b0,
    OwnerD = 1'b1
  } owner_e;

  typedef enum logic {
    OpRd = 1'b0,
    OpWr = 1'b1
  } op_e;

endpackage

// File: rtl/block_mem_array.sv
// Single-port block storage: synchronous write, registered read.
// Contents are deliberately not reset so that they can be preloaded.
module block_mem_array #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] MEMORY [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      MEMORY[addr] <= wdata;
    end
    rdata <= MEMORY[addr];
  end

endmodule

// File: rtl/dual_port_block_memory.sv
// Arbitrates instruction (read-only) and data (read/write) block requests
// onto one shared array with a fixed access latency.
module dual_port_block_memory
  import dual_port_block_memory_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned DEPTH_LOG2 = DefDepthLog2,
  parameter int unsigned LATENCY    = DefLatency
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  op_e                   op_q, op_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;

  logic                  d_req, can_accept, take_d, take_i, commit;
  logic [DEPTH_LOG2-1:0] arr_idx;
  logic                  arr_we;
  logic [DATA_W-1:0]     arr_rdata;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{I_ADDRESS[ADDR_W-1:DEPTH_LOG2], D_ADDRESS[ADDR_W-1:DEPTH_LOG2]};

  assign d_req      = D_READ | D_WRITE;
  assign can_accept = (state_q == StIdle) || (state_q == StDone);
  // In DONE the finishing owner still holds its request; only the other port may start.
  assign take_d = can_accept && d_req && !(state_q == StDone && owner_q == OwnerD);
  assign take_i = can_accept && I_READ && !take_d && !(state_q == StDone && owner_q == OwnerI);
  assign commit = (state_q == StBusy) && (cnt_q == '0);

  // Present the new address on the accept edge so the registered read is ready even at LATENCY 1.
  assign arr_idx = take_d ? D_ADDRESS[DEPTH_LOG2-1:0] :
                   take_i ? I_ADDRESS[DEPTH_LOG2-1:0] : idx_q;
  assign arr_we  = RESET && commit && (op_q == OpWr);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (take_d) begin
          state_d = StBusy;
          owner_d = OwnerD;
          op_d    = D_WRITE ? OpWr : OpRd;
          cnt_d   = CntInit;
          idx_d   = D_ADDRESS[DEPTH_LOG2-1:0];
          wdata_d = D_WRITEDATA;
        end else if (take_i) begin
          state_d = StBusy;
          owner_d = OwnerI;
          op_d    = OpRd;
          cnt_d   = CntInit;
          idx_d   = I_ADDRESS[DEPTH_LOG2-1:0];
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          if (op_q == OpRd) begin
            if (owner_q == OwnerD) begin
              d_rdata_d = arr_rdata;
            end else begin
              i_rdata_d = arr_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= StIdle;
      owner_q   <= OwnerI;
      op_q      <= OpRd;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign I_READDATA = i_rdata_q;
  assign D_READDATA = d_rdata_q;
  assign I_BUSYWAIT = RESET & I_READ & !(state_q == StDone && owner_q == OwnerI);
  assign D_BUSYWAIT = RESET & d_req & !(state_q == StDone && owner_q == OwnerD);

  block_mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_block_mem_array (
    .clk   (CLK),
    .we    (arr_we),
    .addr  (arr_idx),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

endmodule
